// File: rtl/tx_byte_fcs_gen_if.sv
// Handshake bundle between the TX packet buffer / TX encoder side and the
// byte serialiser with FCS insertion.
interface tx_byte_fcs_gen_if #(
  parameter int WORD_WIDTH = 64
);
  logic                  pkt_start;
  logic [15:0]           pkt_len;
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_in_valid;
  logic                  word_rd_en;
  logic                  byte_req;
  logic [7:0]            byte_out;
  logic                  byte_out_strobe;
  logic [15:0]           byte_count;
  logic                  fcs_out_strobe;
  logic                  busy;
  logic                  len_err;
  logic                  req_err;

  // Environment side: drives packet control, buffer head and byte requests.
  modport master (
    output pkt_start, pkt_len, word_in, word_in_valid, byte_req,
    input  word_rd_en, byte_out, byte_out_strobe, byte_count,
           fcs_out_strobe, busy, len_err, req_err
  );

  // Serialiser side.
  modport slave (
    input  pkt_start, pkt_len, word_in, word_in_valid, byte_req,
    output word_rd_en, byte_out, byte_out_strobe, byte_count,
           fcs_out_strobe, busy, len_err, req_err
  );
endinterface

// File: rtl/tx_byte_fcs_gen.sv
// TX byte serialiser: pops payload words from a FWFT buffer, hands out one
// byte per downstream request, and appends the IEEE 802.3 CRC-32 as a
// 4-byte FCS (LSB byte first) so a loopback receiver sees a good frame.
module tx_byte_fcs_gen #(
  parameter int WORD_WIDTH = 64,
  parameter int MAX_LEN    = 4095
) (
  input  logic            clock,
  input  logic            reset,
  tx_byte_fcs_gen_if.slave bus
);
  localparam int                LANES     = WORD_WIDTH / 8;
  localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [15:0]       MIN_LEN_W = 16'd5;
  localparam logic [15:0]       MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [31:0]       CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0]       CRC_INIT  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Reflected CRC-32 update with one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t            state_r;
  logic [15:0]       len_r;
  logic [LANE_W-1:0] lane_r;
  logic [1:0]        fcs_idx_r;
  logic [31:0]       crc_r;
  logic              pending_r;

  logic              req_any_s;
  logic              len_ok_s;
  logic              last_payload_s;
  logic [31:0]       fcs_s;
  logic [7:0]        data_byte_s;
  logic [7:0]        fcs_byte_s;

  // A request is served in the cycle it arrives if possible, so the
  // pending flag only carries requests that had to wait for the buffer.
  always_comb begin
    req_any_s      = bus.byte_req | pending_r;
    len_ok_s       = (bus.pkt_len >= MIN_LEN_W) && (bus.pkt_len <= MAX_LEN_W);
    last_payload_s = (bus.byte_count == (len_r - 16'd5));
    fcs_s          = ~crc_r;
    data_byte_s    = bus.word_in[{lane_r, 3'b000} +: 8];
    fcs_byte_s     = fcs_s[{fcs_idx_r, 3'b000} +: 8];
  end

  // Packet FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r             <= IDLE;
      len_r               <= 16'd0;
      lane_r              <= '0;
      fcs_idx_r           <= 2'd0;
      crc_r               <= CRC_INIT;
      pending_r           <= 1'b0;
      bus.word_rd_en      <= 1'b0;
      bus.byte_out        <= 8'd0;
      bus.byte_out_strobe <= 1'b0;
      bus.byte_count      <= 16'd0;
      bus.fcs_out_strobe  <= 1'b0;
      bus.busy            <= 1'b0;
      bus.len_err         <= 1'b0;
      bus.req_err         <= 1'b0;
    end else begin
      bus.word_rd_en      <= 1'b0;
      bus.byte_out_strobe <= 1'b0;
      bus.fcs_out_strobe  <= 1'b0;
      bus.len_err         <= 1'b0;
      case (state_r)
        IDLE: begin
          pending_r <= 1'b0;
          if (bus.pkt_start) begin
            bus.req_err <= 1'b0;
            if (len_ok_s) begin
              len_r          <= bus.pkt_len;
              bus.byte_count <= 16'd0;
              lane_r         <= '0;
              fcs_idx_r      <= 2'd0;
              crc_r          <= CRC_INIT;
              bus.busy       <= 1'b1;
              state_r        <= DATA;
            end else begin
              bus.len_err <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        DATA: begin
          if (bus.byte_req && pending_r) begin
            bus.req_err <= 1'b1;
          end else begin
            bus.req_err <= bus.req_err;
          end
          if (req_any_s && bus.word_in_valid) begin
            pending_r           <= 1'b0;
            bus.byte_out        <= data_byte_s;
            bus.byte_out_strobe <= 1'b1;
            bus.byte_count      <= bus.byte_count + 16'd1;
            crc_r               <= crc32_byte(crc_r, data_byte_s);
            if (last_payload_s) begin
              // Trailing lanes of the final word are dropped with this pop.
              bus.word_rd_en <= 1'b1;
              lane_r         <= '0;
              state_r        <= FCS;
            end else if (lane_r == LANE_LAST) begin
              bus.word_rd_en <= 1'b1;
              lane_r         <= '0;
            end else begin
              lane_r <= lane_r + 1'b1;
            end
          end else begin
            pending_r <= req_any_s;
          end
        end

        FCS: begin
          if (bus.byte_req && pending_r) begin
            bus.req_err <= 1'b1;
          end else begin
            bus.req_err <= bus.req_err;
          end
          if (req_any_s) begin
            pending_r           <= 1'b0;
            bus.byte_out        <= fcs_byte_s;
            bus.byte_out_strobe <= 1'b1;
            bus.byte_count      <= bus.byte_count + 16'd1;
            if (fcs_idx_r == 2'd3) begin
              bus.fcs_out_strobe <= 1'b1;
              bus.busy           <= 1'b0;
              state_r            <= DONE;
            end else begin
              fcs_idx_r <= fcs_idx_r + 2'd1;
            end
          end else begin
            pending_r <= 1'b0;
          end
        end

        DONE: begin
          pending_r <= 1'b0;
          bus.busy  <= 1'b0;
          state_r   <= IDLE;
        end

        default: begin
          pending_r <= 1'b0;
          bus.busy  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_byte_fcs_gen.sv
// Directed + randomized bench for tx_byte_fcs_gen. A FWFT buffer model feeds
// words; expected byte streams come from the payload plus a software CRC-32
// (and literal constants for the "123456789" check vector).
module tb_tx_byte_fcs_gen;
  logic clock;
  logic reset;
  logic hold;

  tx_byte_fcs_gen_if #(.WORD_WIDTH(64)) bus ();

  tx_byte_fcs_gen #(.WORD_WIDTH(64), .MAX_LEN(4095)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [63:0] mem [0:15];
  logic [7:0]  pl [0:63];
  logic [7:0]  exp_b [0:67];
  int          pl_n = 0;
  int          exp_n = 0;
  int          n_words = 0;
  int          base = 0;
  int          pop_cnt = 0;
  int          strobe_cnt = 0;
  int          head;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // FWFT buffer model: head advances on the edge after a word_rd_en pulse.
  always_comb head = pop_cnt - base;
  assign bus.word_in       = mem[head[3:0]];
  assign bus.word_in_valid = (head < n_words) && !hold;

  always @(posedge clock) begin
    if (bus.word_rd_en) pop_cnt <= pop_cnt + 1;
    if (bus.byte_out_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sw_crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic load_packet(input int len, input bit ascii);
    logic [31:0] fcs;
    pl_n = len - 4;
    exp_n = len;
    for (int i = 0; i < pl_n; i++) pl[i] = ascii ? (8'h31 + 8'(i)) : 8'($urandom);
    for (int w = 0; w < 16; w++) mem[w] = ascii ? 64'd0 : {$urandom, $urandom};
    for (int i = 0; i < pl_n; i++) mem[i / 8][8 * (i % 8) +: 8] = pl[i];
    n_words = (pl_n + 7) / 8;
    for (int i = 0; i < pl_n; i++) exp_b[i] = pl[i];
    if (ascii) begin
      exp_b[9] = 8'h26; exp_b[10] = 8'h39; exp_b[11] = 8'hF4; exp_b[12] = 8'hCB;
    end else begin
      fcs = sw_crc32(pl_n);
      for (int k = 0; k < 4; k++) exp_b[pl_n + k] = fcs[8 * k +: 8];
    end
    base = pop_cnt;
  endtask

  task automatic start_pkt(input int len);
    bus.pkt_len   = 16'(len);
    bus.pkt_start = 1'b1;
    @(negedge clock);
    bus.pkt_start = 1'b0;
  endtask

  task automatic check_byte(input int idx);
    logic exp_rd;
    exp_rd = (idx < pl_n) && (((idx % 8) == 7) || (idx == pl_n - 1));
    check("byte_strobe", bus.byte_out_strobe, 1'b1);
    check("byte_value", bus.byte_out, exp_b[idx]);
    check("byte_count", bus.byte_count, idx + 1);
    check("fcs_strobe", bus.fcs_out_strobe, (idx == exp_n - 1));
    check("word_rd_en", bus.word_rd_en, exp_rd);
    @(negedge clock);
    check("strobe_low", bus.byte_out_strobe, 1'b0);
    check("byte_held", bus.byte_out, exp_b[idx]);
    check("rd_en_low", bus.word_rd_en, 1'b0);
    @(negedge clock);
  endtask

  task automatic serve(input int idx, input int hold_cycles);
    bus.byte_req = 1'b1;
    if (hold_cycles > 0) hold = 1'b1;
    @(negedge clock);
    bus.byte_req = 1'b0;
    for (int c = 0; c < hold_cycles; c++) begin
      check("held_no_strobe", bus.byte_out_strobe, 1'b0);
      if (c == hold_cycles - 1) hold = 1'b0;
      @(negedge clock);
    end
    check_byte(idx);
  endtask

  task automatic run_packet(input int len, input bit ascii, input int bp_idx, input int ovl_idx);
    int s0;
    load_packet(len, ascii);
    s0 = strobe_cnt;
    start_pkt(len);
    check("busy_set", bus.busy, 1'b1);
    check("count_zero", bus.byte_count, 0);
    check("req_err_clear", bus.req_err, 1'b0);
    check("len_err_quiet", bus.len_err, 1'b0);
    for (int idx = 0; idx < len; idx++) begin
      if (idx == ovl_idx) begin
        start_pkt(20);
        check("overlap_busy", bus.busy, 1'b1);
        check("overlap_no_len_err", bus.len_err, 1'b0);
      end
      serve(idx, (idx == bp_idx) ? 10 : 0);
    end
    check("busy_clear", bus.busy, 1'b0);
    check("final_count", bus.byte_count, len);
    check("word_pops", pop_cnt - base, n_words);
    check("bytes_emitted", strobe_cnt - s0, len);
    repeat (3) @(negedge clock);
    check("count_holds", bus.byte_count, len);
  endtask

  task automatic len_test(input int len);
    int p0;
    p0 = pop_cnt;
    start_pkt(len);
    check("len_err_pulse", bus.len_err, 1'b1);
    check("len_busy_low", bus.busy, 1'b0);
    @(negedge clock);
    check("len_err_once", bus.len_err, 1'b0);
    check("len_busy_still_low", bus.busy, 1'b0);
    repeat (2) @(negedge clock);
    check("len_no_pop", pop_cnt - p0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_strobe"}, bus.byte_out_strobe, 1'b0);
    check({tag, "_byte"}, bus.byte_out, 8'd0);
    check({tag, "_count"}, bus.byte_count, 16'd0);
    check({tag, "_fcs"}, bus.fcs_out_strobe, 1'b0);
    check({tag, "_rd"}, bus.word_rd_en, 1'b0);
    check({tag, "_len_err"}, bus.len_err, 1'b0);
    check({tag, "_req_err"}, bus.req_err, 1'b0);
  endtask

  initial begin
    int s0;
    int p0;
    reset = 1'b1;
    hold = 1'b0;
    bus.pkt_start = 1'b0;
    bus.pkt_len = 16'd0;
    bus.byte_req = 1'b0;
    for (int w = 0; w < 16; w++) mem[w] = 64'd0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    check_zero("post_reset");

    // ASCII check vector, then the same packet with back-pressure on byte 3.
    run_packet(13, 1'b1, -1, -1);
    run_packet(13, 1'b1, 2, -1);

    // Length limits.
    len_test(4);
    len_test(4096);
    run_packet(5, 1'b0, -1, -1);

    // pkt_start while busy is ignored.
    run_packet(13, 1'b1, -1, 3);

    // Two back-to-back requests with the buffer empty.
    load_packet(13, 1'b1);
    start_pkt(13);
    s0 = strobe_cnt;
    hold = 1'b1;
    bus.byte_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.byte_req = 1'b0;
    check("req_err_set", bus.req_err, 1'b1);
    check("req_no_byte", bus.byte_out_strobe, 1'b0);
    hold = 1'b0;
    @(negedge clock);
    check_byte(0);
    check("req_single_byte", strobe_cnt - s0, 1);
    for (int idx = 1; idx < 13; idx++) serve(idx, 0);
    check("req_err_sticky", bus.req_err, 1'b1);
    check("req_final_count", bus.byte_count, 16'd13);

    // Reset mid-packet, then a fresh packet must carry the correct FCS.
    load_packet(13, 1'b1);
    start_pkt(13);
    for (int idx = 0; idx < 6; idx++) serve(idx, 0);
    p0 = pop_cnt;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clock);
    check_zero("mid_reset_hold");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_no_pop", pop_cnt - p0, 0);
    check_zero("after_mid_reset");
    run_packet(13, 1'b1, -1, -1);

    // Exactly two full words of payload.
    run_packet(20, 1'b0, -1, -1);

    // Random lengths and payloads.
    for (int r = 0; r < 3; r++) run_packet(int'($urandom_range(5, 40)), 1'b0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tx_byte_fcs_gen.md
Name: tx_byte_fcs_gen

Overview:
- TX-side counterpart of the receiver's byte_out/fcs_ok path.
- Pops 64-bit payload words from a first-word-fall-through packet buffer and serialises them into bytes on demand for the TX encoder chain.
- Computes CRC-32 over the payload and appends it as the 4-byte FCS, so a loopback receiver reports fcs_ok=1.
- Sits between the TX packet buffer and the OFDM TX scrambler/encoder.

Parameters:
- WORD_WIDTH, 64, input word width (multiple of 8; byte 0 = bits [7:0])
- MAX_LEN, 4095, largest accepted pkt_len in bytes, FCS included

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- pkt_start  in  1  one-cycle pulse; begins a packet, samples pkt_len
- pkt_len  in  16  total bytes including 4 FCS bytes
- word_in  in  WORD_WIDTH  head word of packet buffer (FWFT)
- word_in_valid  in  1  word_in holds valid data
- word_rd_en  out  1  one-cycle pop of head word
- byte_req  in  1  one-cycle pulse; downstream requests next byte
- byte_out  out  8  output byte
- byte_out_strobe  out  1  byte_out valid this cycle
- byte_count  out  16  bytes emitted in current packet, FCS included
- fcs_out_strobe  out  1  high with the last FCS byte
- busy  out  1  packet in progress
- len_err  out  1  one-cycle pulse; pkt_len rejected
- req_err  out  1  sticky; byte_req arrived while a request was pending, cleared by pkt_start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, crc=32'hFFFFFFFF, no request pending.
- States:
  - IDLE: on pkt_start with 5<=pkt_len<=MAX_LEN, latch the length, zero byte_count and lane index, set crc=FFFFFFFF, go to DATA, busy=1. Otherwise pulse len_err next cycle and stay in IDLE.
  - DATA: service payload bytes, pkt_len-4 of them.
  - FCS: emit 4 bytes.
  - DONE: one cycle, busy=0, then IDLE.
- pkt_start while busy is ignored; the in-flight packet is unaffected.
- Request handshake:
  - byte_req sets the pending flag. At most one request is outstanding.
  - byte_req while pending sets req_err; the extra request is dropped.
  - byte_req in IDLE/DONE is ignored.
- DATA service:
  - When pending and word_in_valid, the next cycle has byte_out=word_in[8*lane+7:8*lane] and byte_out_strobe=1. Latency from byte_req is 1 cycle when the buffer is non-empty.
  - If word_in_valid=0, the request stays pending until valid. No byte, no error.
- Word pop: word_rd_en pulses in the same cycle the byte is registered, when either the lane is WORD_WIDTH/8-1 or it is the last payload byte. Unused trailing bytes of the final word are discarded with that pop. The lane wraps to 0 after a pop.
- CRC: IEEE 802.3, reflected, polynomial 0xEDB88320, byte-wise update using each payload byte at the moment it is emitted.
- FCS state:
  - fcs = ~crc, sent LSB byte first: fcs[7:0], [15:8], [23:16], [31:24].
  - Each FCS byte is emitted 1 cycle after its byte_req, independent of word_in_valid.
  - fcs_out_strobe coincides with byte_out_strobe on the 4th FCS byte, then the FSM goes to DONE.
- byte_count increments with every byte_out_strobe and equals pkt_len on the final byte. It holds its value through IDLE until the next accepted pkt_start.
- byte_out holds its last value when strobe is low.
- Reset mid-packet: immediate return to IDLE. All outputs clear, CRC reinitialised, pending request dropped. No word_rd_en is issued during or after reset.

Test Plan:
- ASCII "123456789" check vector:
  - Stimulus: pkt_len=13; words 64'h3837363534333231 and 64'h0000000000000039; 13 spaced byte_req pulses.
  - Required: bytes 31..39 then 26 39 F4 CB; fcs_out_strobe on the 13th byte; byte_count=13; exactly 2 word_rd_en pulses.
- Back-pressure:
  - Stimulus: same packet with word_in_valid held low for 10 cycles after the 3rd byte_req.
  - Required: 3rd byte emitted exactly 1 cycle after valid rises; output stream identical to the first test.
- Length checks:
  - pkt_len=4 -> len_err pulse, busy stays 0, no word_rd_en.
  - pkt_len=4096 -> same.
  - pkt_len=5 -> one payload byte plus 4 FCS bytes.
- Overlap and request errors:
  - pkt_start with pkt_len=20 while a 13-byte packet is in flight -> ignored; the 13-byte packet completes correctly.
  - Two byte_req pulses on back-to-back cycles with the buffer empty -> req_err=1, only one byte emitted.
- Reset mid-packet:
  - Stimulus: assert reset after byte 6, then start a new 13-byte packet.
  - Required: all outputs 0 during reset; the new packet yields FCS 26 39 F4 CB (CRC correctly reinitialised).
- Word boundary:
  - Stimulus: pkt_len=20 (16 payload bytes, exactly 2 words).
  - Required: word_rd_en on the 8th and 16th bytes only; FCS matches the software CRC-32.
